// File: rtl/eig_sched_pkg.sv
// Shared definitions for the eigenvalue-unit sequencer: FSM state encoding,
// bit offsets of the four matrix fields inside a packed request, the
// IEEE-754 single-precision exponent constants and the default unit latency.
package eig_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Packed matrix {a1,a2,a3,a4}, a1 in the top word.
    localparam int MAT_A1_LSB = 96;
    localparam int MAT_A2_LSB = 64;
    localparam int MAT_A3_LSB = 32;
    localparam int MAT_A4_LSB = 0;
    localparam int FP_W       = 32;

    localparam logic [7:0] FP_EXP_MAX  = 8'hFF;
    localparam int         LATENCY_DEF = 50;

    // True when a single-precision exponent field marks NaN or Inf.
    function automatic logic fp_exp_is_max(input logic [7:0] exp_f);
        return (exp_f == FP_EXP_MAX);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset (priority back to requester 0)
//   req_i  - request vector, bit N = requester N valid
//   en_i   - grants allowed this cycle
//   upd_i  - a grant is being accepted this cycle; priority moves to the loser
//   gnt_o  - one-hot (or zero) grant, combinational on req_i
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    // Grant the priority holder if it asks, otherwise the other requester.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (prio_q) begin
                gnt_o[1] = req_i[1];
                gnt_o[0] = req_i[0] & ~req_i[1];
            end else begin
                gnt_o[0] = req_i[0];
                gnt_o[1] = req_i[1] & ~req_i[0];
            end
        end else begin
            gnt_o = 2'b00;
        end
    end

    // After an accept the requester that did not win gets priority:
    // winner 0 -> prio 1, winner 1 -> prio 0, i.e. prio follows gnt_o[0].
    always_comb begin
        prio_d = prio_q;
        if (upd_i) begin
            prio_d = gnt_o[0];
        end else begin
            prio_d = prio_q;
        end
    end

    // Priority register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/eig_sched.sv
// Sequencer and two-requester arbiter in front of the shared 2x2 eigenvalue
// unit. A granted matrix is latched onto the unit's operand bus and held for
// LATENCY cycles, then the unit outputs are captured and returned, tagged
// with the requester id, through a valid/ready result port.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   reqN_valid/reqN_ready/reqN_mat - requester N matrix handshake (N=0,1)
//   eu_a1..eu_a4                   - operands to the eigenvalue unit
//   eu_v1, eu_v2                   - eigenvalue unit results
//   res_valid/res_ready            - result handshake
//   res_v1, res_v2, res_id, res_nan- captured result, owner, NaN/Inf flag
//   busy                           - a matrix is in flight or being returned
module eig_sched
    import eig_sched_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int CNT_W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_mat,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_mat,
    output logic [31:0]  eu_a1,
    output logic [31:0]  eu_a2,
    output logic [31:0]  eu_a3,
    output logic [31:0]  eu_a4,
    input  logic [31:0]  eu_v1,
    input  logic [31:0]  eu_v2,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [31:0]  res_v1,
    output logic [31:0]  res_v2,
    output logic         res_id,
    output logic         res_nan,
    output logic         busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      eu_a1_q, eu_a2_q, eu_a3_q, eu_a4_q;
    logic             id_q;
    logic             res_valid_q;
    logic [31:0]      res_v1_q, res_v2_q;
    logic             res_id_q;
    logic             res_nan_q;
    logic             busy_q;

    logic [1:0]   gnt_s;
    logic         idle_s;
    logic         accept_s;
    logic         win_s;
    logic [127:0] mat_s;

    assign idle_s   = (state_q == IDLE);
    assign accept_s = gnt_s[0] | gnt_s[1];
    assign win_s    = gnt_s[1];
    assign mat_s    = win_s ? req1_mat : req0_mat;

    rr_arb2 u_arb (
        .clk_i (clk),
        .rst_i (rst),
        .req_i ({req1_valid, req0_valid}),
        .en_i  (idle_s),
        .upd_i (accept_s),
        .gnt_o (gnt_s)
    );

    assign req0_ready = gnt_s[0];
    assign req1_ready = gnt_s[1];
    assign eu_a1      = eu_a1_q;
    assign eu_a2      = eu_a2_q;
    assign eu_a3      = eu_a3_q;
    assign eu_a4      = eu_a4_q;
    assign res_valid  = res_valid_q;
    assign res_v1     = res_v1_q;
    assign res_v2     = res_v2_q;
    assign res_id     = res_id_q;
    assign res_nan    = res_nan_q;
    assign busy       = busy_q;

    // Sequencer FSM with its operand, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            eu_a1_q     <= 32'h0;
            eu_a2_q     <= 32'h0;
            eu_a3_q     <= 32'h0;
            eu_a4_q     <= 32'h0;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_v1_q    <= 32'h0;
            res_v2_q    <= 32'h0;
            res_id_q    <= 1'b0;
            res_nan_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        eu_a1_q <= mat_s[MAT_A1_LSB +: FP_W];
                        eu_a2_q <= mat_s[MAT_A2_LSB +: FP_W];
                        eu_a3_q <= mat_s[MAT_A3_LSB +: FP_W];
                        eu_a4_q <= mat_s[MAT_A4_LSB +: FP_W];
                        id_q    <= win_s;
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    // cnt reaches LATENCY-1 on the LATENCY-th edge after accept,
                    // which is when the unit output is trustworthy.
                    if (cnt_q == CNT_LAST) begin
                        res_v1_q    <= eu_v1;
                        res_v2_q    <= eu_v2;
                        res_nan_q   <= fp_exp_is_max(eu_v1[30:23]) |
                                       fp_exp_is_max(eu_v2[30:23]);
                        res_id_q    <= id_q;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
